// File: rtl/axi_rd_slave_switch_n_if.sv
// Bus bundle for the N-way AXI read switch: upstream AR/R plus flattened per-slave AR/R.
// The slave modport is the switch side; the master modport is the surrounding fabric side.
interface axi_rd_slave_switch_n_if #(
   parameter int NUM_SLAVES = 3,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int RESP_WIDTH = 2
);
   logic [ID_WIDTH-1:0]              up_arid;
   logic [ADDR_WIDTH-1:0]            up_araddr;
   logic [7:0]                       up_arlen;
   logic [2:0]                       up_arsize;
   logic [1:0]                       up_arburst;
   logic                             up_arvalid;
   logic                             up_arready;
   logic [ID_WIDTH-1:0]              up_rid;
   logic [DATA_WIDTH-1:0]            up_rdata;
   logic [RESP_WIDTH-1:0]            up_rresp;
   logic                             up_rlast;
   logic                             up_rvalid;
   logic                             up_rready;

   logic [NUM_SLAVES*ID_WIDTH-1:0]   dn_arid;
   logic [NUM_SLAVES*ADDR_WIDTH-1:0] dn_araddr;
   logic [NUM_SLAVES*8-1:0]          dn_arlen;
   logic [NUM_SLAVES*3-1:0]          dn_arsize;
   logic [NUM_SLAVES*2-1:0]          dn_arburst;
   logic [NUM_SLAVES-1:0]            dn_arvalid;
   logic [NUM_SLAVES-1:0]            dn_arready;
   logic [NUM_SLAVES*ID_WIDTH-1:0]   dn_rid;
   logic [NUM_SLAVES*DATA_WIDTH-1:0] dn_rdata;
   logic [NUM_SLAVES*RESP_WIDTH-1:0] dn_rresp;
   logic [NUM_SLAVES-1:0]            dn_rlast;
   logic [NUM_SLAVES-1:0]            dn_rvalid;
   logic [NUM_SLAVES-1:0]            dn_rready;

   modport slave (
      input  up_arid, up_araddr, up_arlen, up_arsize, up_arburst, up_arvalid,
      output up_arready,
      output up_rid, up_rdata, up_rresp, up_rlast, up_rvalid,
      input  up_rready,
      output dn_arid, dn_araddr, dn_arlen, dn_arsize, dn_arburst, dn_arvalid,
      input  dn_arready,
      input  dn_rid, dn_rdata, dn_rresp, dn_rlast, dn_rvalid,
      output dn_rready
   );

   modport master (
      output up_arid, up_araddr, up_arlen, up_arsize, up_arburst, up_arvalid,
      input  up_arready,
      input  up_rid, up_rdata, up_rresp, up_rlast, up_rvalid,
      output up_rready,
      input  dn_arid, dn_araddr, dn_arlen, dn_arsize, dn_arburst, dn_arvalid,
      output dn_arready,
      output dn_rid, dn_rdata, dn_rresp, dn_rlast, dn_rvalid,
      input  dn_rready
   );
endinterface

// File: rtl/axi_rd_slave_switch_n.sv
// AXI read switch, one master to NUM_SLAVES slaves, with outstanding-burst route locking and a
// DECERR responder for unmapped reads. Define RD_SWITCH_AR_SLICE_EN for a 2-entry AR skid buffer.
module axi_rd_slave_switch_n #(
   parameter int NUM_SLAVES      = 3,
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int ID_WIDTH        = 4,
   parameter int RESP_WIDTH      = 2,
   parameter int SEL_BITS        = 2,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                   sys_clk,
   input  logic                   sys_rstn,
   input  logic                   ar_en,
   axi_rd_slave_switch_n_if.slave bus,
   output logic                   busy
);
   localparam int TGT_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DECERR} state_t;

   state_t              state_reg;
   logic [TGT_W-1:0]    tgt_reg;
   logic [CNT_W-1:0]    cnt_reg;
   logic [ID_WIDTH-1:0] derr_id_reg;
   logic [7:0]          derr_len_reg;
   logic [7:0]          derr_beat_reg;

   // AR request as seen by the decoder (upstream directly, or the skid-buffer head)
   logic [ID_WIDTH-1:0]   a_id;
   logic [ADDR_WIDTH-1:0] a_addr;
   logic [7:0]            a_len;
   logic [2:0]            a_size;
   logic [1:0]            a_burst;
   logic                  a_valid;
   logic                  a_ready;

`ifdef RD_SWITCH_AR_SLICE_EN
   localparam int AR_W = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2;
   logic [AR_W-1:0] buf_mem [0:1];
   logic            buf_wr_reg;
   logic            buf_rd_reg;
   logic [1:0]      buf_cnt_reg;
   logic            buf_enq;
   logic            buf_deq;

   assign bus.up_arready = sys_rstn && (buf_cnt_reg != 2'd2);
   assign buf_enq = bus.up_arvalid && bus.up_arready;
   assign buf_deq = a_valid && a_ready;
   assign a_valid = (buf_cnt_reg != 2'd0);
   assign {a_id, a_addr, a_len, a_size, a_burst} = buf_mem[buf_rd_reg];

   always_ff @(posedge sys_clk) begin
      if (buf_enq)
         buf_mem[buf_wr_reg] <= {bus.up_arid, bus.up_araddr, bus.up_arlen, bus.up_arsize, bus.up_arburst};
   end

   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         buf_wr_reg  <= 1'b0;
         buf_rd_reg  <= 1'b0;
         buf_cnt_reg <= 2'd0;
      end else begin
         if (buf_enq) buf_wr_reg <= ~buf_wr_reg;
         if (buf_deq) buf_rd_reg <= ~buf_rd_reg;
         buf_cnt_reg <= buf_cnt_reg + 2'(buf_enq) - 2'(buf_deq);
      end
   end
`else
   assign a_id           = bus.up_arid;
   assign a_addr         = bus.up_araddr;
   assign a_len          = bus.up_arlen;
   assign a_size         = bus.up_arsize;
   assign a_burst        = bus.up_arburst;
   assign a_valid        = bus.up_arvalid;
   assign bus.up_arready = a_ready;
`endif

   logic [SEL_BITS-1:0]   sel;
   logic [TGT_W-1:0]      k_idx;
   logic                  mapped;
   logic                  map_ok;
   logic                  unmap_ok;
   logic                  ar_map_hs;
   logic                  ar_unmap_hs;
   logic                  r_route;
   logic                  r_last_hs;
   logic [CNT_W-1:0]      cnt_next;
   logic [NUM_SLAVES-1:0] sel_hit;
   logic [ID_WIDTH-1:0]   r_id_arr   [NUM_SLAVES];
   logic [DATA_WIDTH-1:0] r_data_arr [NUM_SLAVES];
   logic [RESP_WIDTH-1:0] r_resp_arr [NUM_SLAVES];

   assign sel    = a_addr[ADDR_WIDTH-1 -: SEL_BITS];
   assign k_idx  = TGT_W'(sel - 1'b1);
   assign mapped = (sel != '0) && (int'(sel) <= NUM_SLAVES);

   // A new target is only taken once nothing is outstanding at the start of the cycle
   assign map_ok   = sys_rstn && ar_en && (state_reg != ST_DECERR) && mapped &&
                     ((cnt_reg == '0) || ((tgt_reg == k_idx) && (cnt_reg < CNT_MAX)));
   assign unmap_ok = sys_rstn && ar_en && !mapped && (state_reg == ST_IDLE) && (cnt_reg == '0);

   assign a_ready     = (|(sel_hit & bus.dn_arready)) || unmap_ok;
   assign ar_map_hs   = a_valid && (|(sel_hit & bus.dn_arready));
   assign ar_unmap_hs = a_valid && unmap_ok;
   assign r_route     = sys_rstn && (state_reg == ST_ACTIVE);

   for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
      assign sel_hit[gi]        = map_ok && (k_idx == TGT_W'(gi));
      assign bus.dn_arvalid[gi] = sel_hit[gi] && a_valid;
      assign bus.dn_arid[gi*ID_WIDTH +: ID_WIDTH]       = sel_hit[gi] ? a_id    : '0;
      assign bus.dn_araddr[gi*ADDR_WIDTH +: ADDR_WIDTH] = sel_hit[gi] ? a_addr  : '0;
      assign bus.dn_arlen[gi*8 +: 8]                    = sel_hit[gi] ? a_len   : '0;
      assign bus.dn_arsize[gi*3 +: 3]                   = sel_hit[gi] ? a_size  : '0;
      assign bus.dn_arburst[gi*2 +: 2]                  = sel_hit[gi] ? a_burst : '0;
      assign bus.dn_rready[gi] = r_route && (tgt_reg == TGT_W'(gi)) && bus.up_rready;
      assign r_id_arr[gi]   = bus.dn_rid[gi*ID_WIDTH +: ID_WIDTH];
      assign r_data_arr[gi] = bus.dn_rdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign r_resp_arr[gi] = bus.dn_rresp[gi*RESP_WIDTH +: RESP_WIDTH];
   end

   always_comb begin
      bus.up_rid    = '0;
      bus.up_rdata  = '0;
      bus.up_rresp  = '0;
      bus.up_rlast  = 1'b0;
      bus.up_rvalid = 1'b0;
      if (r_route) begin
         bus.up_rid    = r_id_arr[tgt_reg];
         bus.up_rdata  = r_data_arr[tgt_reg];
         bus.up_rresp  = r_resp_arr[tgt_reg];
         bus.up_rlast  = bus.dn_rlast[tgt_reg];
         bus.up_rvalid = bus.dn_rvalid[tgt_reg];
      end else if (sys_rstn && (state_reg == ST_DECERR)) begin
         bus.up_rid    = derr_id_reg;
         bus.up_rresp  = '1;
         bus.up_rlast  = (derr_beat_reg == derr_len_reg);
         bus.up_rvalid = 1'b1;
      end
   end

   assign r_last_hs = r_route && bus.up_rvalid && bus.up_rready && bus.up_rlast;
   assign cnt_next  = cnt_reg + CNT_W'(ar_map_hs) - CNT_W'(r_last_hs);

   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         state_reg     <= ST_IDLE;
         tgt_reg       <= '0;
         cnt_reg       <= '0;
         derr_id_reg   <= '0;
         derr_len_reg  <= '0;
         derr_beat_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE, ST_ACTIVE: begin
               if (ar_unmap_hs) begin
                  derr_id_reg   <= a_id;
                  derr_len_reg  <= a_len;
                  derr_beat_reg <= '0;
                  state_reg     <= ST_DECERR;
               end else begin
                  cnt_reg <= cnt_next;
                  if (ar_map_hs) tgt_reg <= k_idx;
                  state_reg <= (cnt_next != '0) ? ST_ACTIVE : ST_IDLE;
               end
            end
            ST_DECERR: begin
               if (bus.up_rready) begin
                  if (derr_beat_reg == derr_len_reg) state_reg <= ST_IDLE;
                  else derr_beat_reg <= derr_beat_reg + 8'd1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign busy = (cnt_reg != '0) || (state_reg == ST_DECERR);
endmodule

// File: tb/tb_axi_rd_slave_switch_n.sv
// Randomized bench for axi_rd_slave_switch_n: a transaction-level model (outstanding-burst queue,
// DECERR beat count, single responding slave) predicts every upstream/downstream output per cycle.
module tb_axi_rd_slave_switch_n;
   localparam int NS = 3;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int IW = 4;
   localparam int RW = 2;
   localparam int MO = 4;

   logic clk   = 1'b0;
   logic rstn  = 1'b0;
   logic ar_en = 1'b0;
   logic busy;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   axi_rd_slave_switch_n_if #(.NUM_SLAVES(NS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                              .ID_WIDTH(IW), .RESP_WIDTH(RW)) bus ();

   axi_rd_slave_switch_n #(.NUM_SLAVES(NS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
                           .RESP_WIDTH(RW), .SEL_BITS(2), .MAX_OUTSTANDING(MO)) dut (
      .sys_clk (clk),
      .sys_rstn(rstn),
      .ar_en   (ar_en),
      .bus     (bus),
      .busy    (busy)
   );

   // Reference model: bursts accepted but not yet completed, all owned by model_tgt
   int              out_len[$];
   int              out_id[$];
   int              model_tgt = 0;
   int              beat      = 0;
   bit              pres      = 1'b0;
   logic [DW-1:0]   pres_data = '0;
   logic [RW-1:0]   pres_resp = '0;
   int              derr_left = 0;
   logic [IW-1:0]   derr_id   = '0;

   bit              ar_pend  = 1'b0;
   logic [IW-1:0]   ar_id    = '0;
   logic [AW-1:0]   ar_addr  = '0;
   logic [7:0]      ar_len   = '0;
   logic [2:0]      ar_size  = '0;
   logic [1:0]      ar_burst = '0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic check_outputs_zero();
      check("rst_arready", bus.up_arready, 0);
      check("rst_dn_arvalid", bus.dn_arvalid, 0);
      check("rst_dn_araddr", bus.dn_araddr, 0);
      check("rst_dn_arid_len", {bus.dn_arid, bus.dn_arlen, bus.dn_arsize, bus.dn_arburst}, 0);
      check("rst_dn_rready", bus.dn_rready, 0);
      check("rst_up_r", {bus.up_rvalid, bus.up_rid, bus.up_rdata, bus.up_rresp, bus.up_rlast}, 0);
      check("rst_busy", busy, 0);
   endtask

   task automatic clear_model();
      out_len.delete();
      out_id.delete();
      model_tgt = 0;
      beat      = 0;
      pres      = 1'b0;
      derr_left = 0;
   endtask

   task automatic run_cycle(input int phase, input int cyc);
      int              sel;
      int              k;
      int              p_r;
      bit              mapped, ok_map, ok_unmap, exp_ardy, ar_hs, r_hs;
      logic [NS-1:0]   exp_dnv, exp_rr;
      logic [NS*IW-1:0] exp_id_v;
      logic [NS*AW-1:0] exp_addr_v;
      logic [NS*8-1:0]  exp_len_v;
      logic [NS*3-1:0]  exp_size_v;
      logic [NS*2-1:0]  exp_burst_v;
      logic            exp_rvalid, exp_rlast;
      logic [IW-1:0]   exp_rid;
      logic [DW-1:0]   exp_rdata;
      logic [RW-1:0]   exp_rresp;

      if (!ar_pend && $urandom_range(99) < 60) begin
         case (phase)
            1:       sel = ($urandom_range(99) < 85) ? 2 : int'($urandom_range(0, 3));
            2:       sel = ($urandom_range(99) < 70) ? 2 : int'($urandom_range(0, 3));
            default: sel = int'($urandom_range(0, 3));
         endcase
         ar_pend  = 1'b1;
         ar_id    = IW'($urandom);
         ar_addr  = {2'(sel), 30'($urandom)};
         ar_len   = 8'($urandom_range(0, 3));
         ar_size  = 3'($urandom);
         ar_burst = 2'($urandom);
      end
      bus.up_arvalid = ar_pend;
      bus.up_arid    = ar_id;
      bus.up_araddr  = ar_addr;
      bus.up_arlen   = ar_len;
      bus.up_arsize  = ar_size;
      bus.up_arburst = ar_burst;
      ar_en          = ($urandom_range(99) < 90);
      bus.up_rready  = (phase == 2) ? ((cyc % 2) == 0) : ($urandom_range(99) < 80);
      p_r = (phase == 1) ? 5 : ((phase == 2) ? 100 : 70);

      for (int j = 0; j < NS; j++) begin
         bus.dn_arready[j]         = ($urandom_range(99) < 75);
         bus.dn_rvalid[j]          = 1'b0;
         bus.dn_rdata[j*DW +: DW]  = $urandom;
         bus.dn_rid[j*IW +: IW]    = IW'($urandom);
         bus.dn_rresp[j*RW +: RW]  = RW'($urandom);
         bus.dn_rlast[j]           = 1'($urandom);
      end
      if (out_len.size() > 0) begin
         if (!pres && $urandom_range(99) < p_r) begin
            pres      = 1'b1;
            pres_data = $urandom;
            pres_resp = RW'($urandom);
         end
         bus.dn_rvalid[model_tgt] = pres;
         if (pres) begin
            bus.dn_rdata[model_tgt*DW +: DW] = pres_data;
            bus.dn_rid[model_tgt*IW +: IW]   = IW'(out_id[0]);
            bus.dn_rresp[model_tgt*RW +: RW] = pres_resp;
            bus.dn_rlast[model_tgt]          = (beat == out_len[0]);
         end
      end
      #2;

      sel      = int'(ar_addr[AW-1 -: 2]);
      mapped   = (sel >= 1) && (sel <= NS);
      k        = sel - 1;
      ok_map   = ar_en && (derr_left == 0) && mapped &&
                 ((out_len.size() == 0) || ((model_tgt == k) && (out_len.size() < MO)));
      ok_unmap = ar_en && !mapped && (out_len.size() == 0) && (derr_left == 0);
      exp_ardy = ok_map ? bus.dn_arready[k] : ok_unmap;

      exp_dnv = '0; exp_id_v = '0; exp_addr_v = '0; exp_len_v = '0; exp_size_v = '0; exp_burst_v = '0;
      if (ok_map) begin
         exp_dnv[k]              = ar_pend;
         exp_id_v[k*IW +: IW]    = ar_id;
         exp_addr_v[k*AW +: AW]  = ar_addr;
         exp_len_v[k*8 +: 8]     = ar_len;
         exp_size_v[k*3 +: 3]    = ar_size;
         exp_burst_v[k*2 +: 2]   = ar_burst;
      end

      exp_rr = '0; exp_rvalid = 1'b0; exp_rlast = 1'b0; exp_rid = '0; exp_rdata = '0; exp_rresp = '0;
      if (derr_left > 0) begin
         exp_rvalid = 1'b1;
         exp_rid    = derr_id;
         exp_rresp  = 2'b11;
         exp_rlast  = (derr_left == 1);
      end else if (out_len.size() > 0) begin
         exp_rr[model_tgt] = bus.up_rready;
         exp_rvalid        = pres;
         if (pres) begin
            exp_rid   = IW'(out_id[0]);
            exp_rdata = pres_data;
            exp_rresp = pres_resp;
            exp_rlast = (beat == out_len[0]);
         end
      end

      check("up_arready", bus.up_arready, exp_ardy);
      check("dn_arvalid", bus.dn_arvalid, exp_dnv);
      check("dn_araddr", bus.dn_araddr, exp_addr_v);
      check("dn_ar_fields", {bus.dn_arid, bus.dn_arlen, bus.dn_arsize, bus.dn_arburst},
            {exp_id_v, exp_len_v, exp_size_v, exp_burst_v});
      check("dn_rready", bus.dn_rready, exp_rr);
      check("up_rvalid", bus.up_rvalid, exp_rvalid);
      if (exp_rvalid || (derr_left == 0 && out_len.size() == 0))
         check("up_r_beat", {bus.up_rid, bus.up_rdata, bus.up_rresp, bus.up_rlast},
               {exp_rid, exp_rdata, exp_rresp, exp_rlast});
      check("busy", busy, (out_len.size() > 0) || (derr_left > 0));

      ar_hs = ar_pend && exp_ardy;
      r_hs  = exp_rvalid && bus.up_rready;
      @(posedge clk);
      #1;

      if (r_hs) begin
         if (derr_left > 0) begin
            derr_left--;
            if (derr_left == 0) $display("R   decerr burst done id=%0d", derr_id);
         end else begin
            pres = 1'b0;
            if (beat == out_len[0]) begin
               $display("R   slave=%0d burst done id=%0d len=%0d", model_tgt, out_id[0], out_len[0]);
               void'(out_len.pop_front());
               void'(out_id.pop_front());
               beat = 0;
            end else begin
               beat++;
            end
         end
      end
      if (ar_hs) begin
         if (mapped) begin
            out_len.push_back(int'(ar_len));
            out_id.push_back(int'(ar_id));
            model_tgt = k;
            $display("AR  slave=%0d id=%0d len=%0d outstanding=%0d", k, ar_id, ar_len, out_len.size());
         end else begin
            derr_left = int'(ar_len) + 1;
            derr_id   = ar_id;
            $display("AR  unmapped addr=%08h id=%0d len=%0d", ar_addr, ar_id, ar_len);
         end
         ar_pend = 1'b0;
      end
   endtask

   initial begin
      bus.up_arvalid = 1'b1;
      bus.up_arid    = 4'd1;
      bus.up_araddr  = 32'h4000_0000;
      bus.up_arlen   = 8'd3;
      bus.up_arsize  = 3'd2;
      bus.up_arburst = 2'd1;
      bus.up_rready  = 1'b1;
      bus.dn_arready = '1;
      bus.dn_rid     = '1;
      bus.dn_rdata   = '1;
      bus.dn_rresp   = '1;
      bus.dn_rlast   = '1;
      bus.dn_rvalid  = '1;
      ar_en          = 1'b1;
      rstn           = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero();
      rstn = 1'b1;

      ar_pend  = 1'b1;
      ar_id    = 4'd1;
      ar_addr  = 32'h4000_0000;
      ar_len   = 8'd3;
      ar_size  = 3'd2;
      ar_burst = 2'd1;

      for (int cyc = 0; cyc < 1200; cyc++) begin
         if (cyc == 850) begin
            $display("RST asserted mid-run, outstanding=%0d", out_len.size());
            rstn = 1'b0;
            #1;
            check_outputs_zero();
            clear_model();
            repeat (2) @(posedge clk);
            #1;
            rstn     = 1'b1;
            ar_pend  = 1'b1;
            ar_id    = 4'd6;
            ar_addr  = 32'h4000_1000;
            ar_len   = 8'd1;
         end
         run_cycle((cyc < 400) ? 0 : (cyc < 700) ? 1 : (cyc < 1000) ? 2 : 0, cyc);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
